a2_1_rtl: RTL and testbench

Registered 8-to-3 priority encoder with a valid flag. It samples an 8-bit request vector `d` and reports the index of the highest-priority set bit on `y`. `v` indicates that at least one bit was set. It is a small standalone combinational-plus-register block used as a leaf in class-assignment designs. A testbench drives `d` and observes `y`.

---
 rtl/a2_1_rtl.sv | 52 +++++
 tb/tb_a2_1_rtl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/a2_1_rtl.sv
// Registered 8-to-3 priority encoder with valid flag.
// LSB_PRIORITY selects whether bit 7 (0) or bit 0 (1) wins when several requests are set.
module a2_1_rtl #(
  parameter int unsigned LSB_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [7:0] d,
  output logic [2:0] y,
  output logic       v
);

  logic [2:0] enc;
  logic [2:0] y_q, y_d;
  logic       v_q, v_d;

  // The scan order is chosen so that the last match is the winning bit.
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (LSB_PRIORITY == 0) begin
        if (d[i]) enc = 3'(i);
      end else begin
        if (d[7 - i]) enc = 3'(7 - i);
      end
    end
  end

  always_comb begin
    y_d = y_q;
    v_d = v_q;
    if (e) begin
      y_d = enc;
      v_d = |d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign y = y_q;
  assign v = v_q;

endmodule

// File: tb/tb_a2_1_rtl.sv
// Self-checking bench for a2_1_rtl: both priority directions run side by side on shared inputs,
// compared against an arithmetic (log2-based) reference of the priority rule.
module tb_a2_1_rtl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic [7:0] d;
  logic [2:0] y0, y1;
  logic       v0, v1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] exp_y0, exp_y1;
  logic       exp_v0, exp_v1;

  always #5 clk = ~clk;

  a2_1_rtl #(.LSB_PRIORITY(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .e(e), .d(d), .y(y0), .v(v0)
  );

  a2_1_rtl #(.LSB_PRIORITY(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .e(e), .d(d), .y(y1), .v(v1)
  );

  // Highest set bit index = floor(log2(x)); lowest = log2 of the isolated lowest set bit.
  function automatic logic [2:0] ref_msb(input logic [7:0] x);
    if (x == 8'h00) return 3'd0;
    return 3'($clog2(int'(x) + 1) - 1);
  endfunction

  function automatic logic [2:0] ref_lsb(input logic [7:0] x);
    logic [7:0] iso;
    if (x == 8'h00) return 3'd0;
    iso = x & (~x + 8'd1);
    return 3'($clog2(int'(iso)));
  endfunction

  task automatic model_reset();
    exp_y0 = '0; exp_v0 = 1'b0;
    exp_y1 = '0; exp_v1 = 1'b0;
  endtask

  // Drive inputs, take one rising edge, advance the reference, settle 1ns past the edge.
  task automatic apply(input logic [7:0] dv, input logic ev);
    d = dv;
    e = ev;
    @(posedge clk);
    if (rst_n && ev) begin
      exp_y0 = ref_msb(dv); exp_v0 = (dv != 8'h00);
      exp_y1 = ref_lsb(dv); exp_v1 = (dv != 8'h00);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      apply(8'hFF, 1'b1);
      tests_run++;
      if ({y0, v0, y1, v1} !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_hold: got y0=%0d v0=%0b y1=%0d v1=%0b, expected all 0", y0, v0, y1, v1);
      end
    end
    rst_n = 1'b1;
    apply(8'hFF, 1'b1);
    tests_run++;
    if ({y0, v0, y1, v1} !== {3'd7, 1'b1, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y0=7 v0=1 y1=0 v1=1",
               y0, v0, y1, v1);
    end
  endtask

  task automatic test_priority();
    logic [7:0] vec [6] = '{8'b1000_0001, 8'b0010_0100, 8'b0000_0001, 8'h00, 8'b1010_1000, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      apply(vec[i], 1'b1);
      tests_run++;
      if ({y0, v0, y1, v1} !== {exp_y0, exp_v0, exp_y1, exp_v1}) begin
        tests_failed++;
        $display("FAIL priority d=%02h: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y0=%0d v0=%0b y1=%0d v1=%0b",
                 vec[i], y0, v0, y1, v1, exp_y0, exp_v0, exp_y1, exp_v1);
      end
    end
  endtask

  task automatic test_walking_one();
    for (int i = 0; i < 8; i++) begin
      apply(8'(1 << i), 1'b1);
      tests_run++;
      if ({y0, v0, y1, v1} !== {3'(i), 1'b1, 3'(i), 1'b1}) begin
        tests_failed++;
        $display("FAIL walking_one i=%0d: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y=%0d v=1",
                 i, y0, v0, y1, v1, i);
      end
    end
  endtask

  task automatic test_enable_hold();
    apply(8'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(8'h02, 1'b0);
      tests_run++;
      if ({y0, v0, y1, v1} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
        tests_failed++;
        $display("FAIL enable_hold cyc=%0d: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y=4 v=1",
                 i, y0, v0, y1, v1);
      end
    end
    apply(8'h02, 1'b1);
    tests_run++;
    if ({y0, v0, y1, v1} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL enable_resume: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y=1 v=1", y0, v0, y1, v1);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       en;
    for (int i = 0; i < 20; i++) begin
      r  = 8'($urandom);
      en = ($urandom_range(0, 4) != 0);
      apply(r, en);
      tests_run++;
      if ({y0, v0, y1, v1} !== {exp_y0, exp_v0, exp_y1, exp_v1}) begin
        tests_failed++;
        $display("FAIL random i=%0d d=%02h e=%0b: got y0=%0d v0=%0b y1=%0d v1=%0b, expected y0=%0d v0=%0b y1=%0d v1=%0b",
                 i, r, en, y0, v0, y1, v1, exp_y0, exp_v0, exp_y1, exp_v1);
      end
      if (i == 9) begin
        // Asynchronous pulse between edges: outputs must clear without a clock.
        d = 8'hFF;
        e = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({y0, v0, y1, v1} !== 8'h00) begin
          tests_failed++;
          $display("FAIL async_reset: got y0=%0d v0=%0b y1=%0d v1=%0b, expected all 0", y0, v0, y1, v1);
        end
        #1;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    e     = 1'b0;
    d     = '0;
    model_reset();
    test_reset();
    test_priority();
    test_walking_one();
    test_enable_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
